// File: rtl/order_gate.sv
// order_gate: turns registered buy/sell decisions into queued market orders.
// It applies a per-side position limit, a post-order cooldown, conflict
// rejection and an external halt. Orders leave through a valid/ready port
// fed by a small first-word-fall-through FIFO.
module order_gate #(
  parameter int data_width      = 8,
  parameter int max_position    = 4,
  parameter int cooldown_cycles = 4,
  parameter int fifo_depth      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  halt,
  input  logic                  buy_signal,
  input  logic                  sell_signal,
  input  logic                  data_valid_end,
  input  logic [data_width-1:0] price,
  input  logic                  order_ready,
  output logic                  order_valid,
  output logic                  order_side,
  output logic [data_width-1:0] order_price,
  output logic [7:0]            position,
  output logic                  fifo_full,
  output logic [7:0]            drop_count,
  output logic [1:0]            state_out
);

  localparam int aw = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cw = (cooldown_cycles > 0) ? $clog2(cooldown_cycles + 1) : 1;
  localparam logic signed [7:0] pos_max = 8'(max_position);
  localparam logic signed [7:0] pos_min = 8'(-max_position);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COOLDOWN = 2'b01,
    HALT     = 2'b10
  } state_t;

  state_t              state, state_nxt;
  logic [cw-1:0]       cd_cnt, cd_cnt_nxt;
  logic [aw:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [data_width:0] mem [fifo_depth];
  logic [data_width:0] head_nxt;
  logic signed [7:0]   pos_s;
  logic                is_dec, conflict, pos_ok, accept, drop, deq, empty_nxt;

  assign pos_s     = position;
  assign is_dec    = enable && data_valid_end && (buy_signal || sell_signal);
  assign conflict  = buy_signal && sell_signal;
  assign pos_ok    = buy_signal ? (pos_s < pos_max) : (pos_s > pos_min);
  assign fifo_full = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign deq       = order_valid && order_ready;
  assign drop      = is_dec && !accept;
  assign state_out = state;

  // Next-state, cooldown counter and acceptance decision; halt overrides all.
  always_comb begin
    state_nxt  = state;
    cd_cnt_nxt = cd_cnt;
    accept     = 1'b0;
    if (halt) begin
      state_nxt = HALT;
    end else begin
      case (state)
        IDLE: begin
          if (is_dec && !conflict && !fifo_full && pos_ok) begin
            accept = 1'b1;
            if (cooldown_cycles > 0) begin
              state_nxt  = COOLDOWN;
              cd_cnt_nxt = cw'(cooldown_cycles);
            end
          end
        end
        COOLDOWN: begin
          cd_cnt_nxt = cd_cnt - cw'(1);
          if (cd_cnt == cw'(1)) state_nxt = IDLE;
        end
        HALT: begin
          state_nxt  = IDLE;
          cd_cnt_nxt = '0;
        end
        default: begin
          state_nxt  = IDLE;
          cd_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State register and cooldown counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cd_cnt <= cd_cnt_nxt;
    end
  end

  // Net position moves at enqueue; rejected decisions bump a saturating count.
  always_ff @(posedge clk) begin
    if (rst) begin
      position   <= '0;
      drop_count <= '0;
    end else begin
      if (accept) position <= buy_signal ? position + 8'd1 : position - 8'd1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // Pointer updates and the head entry that will be presented after this edge.
  // When the only entry after the edge is the one being written now, it is
  // forwarded from the inputs because the storage write has not landed yet.
  always_comb begin
    wr_ptr_nxt = accept ? wr_ptr + (aw+1)'(1) : wr_ptr;
    rd_ptr_nxt = deq ? rd_ptr + (aw+1)'(1) : rd_ptr;
    empty_nxt  = (rd_ptr_nxt == wr_ptr_nxt);
    if (accept && rd_ptr_nxt == wr_ptr) head_nxt = {sell_signal, price};
    else                                head_nxt = mem[rd_ptr_nxt[aw-1:0]];
  end

  // FIFO storage; reset only needs the pointers.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[aw-1:0]] <= {sell_signal, price};
  end

  // FIFO pointers and registered output stage; data holds when the FIFO empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      order_valid <= 1'b0;
      order_side  <= 1'b0;
      order_price <= '0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      order_valid <= !empty_nxt;
      if (!empty_nxt) {order_side, order_price} <= head_nxt;
    end
  end

endmodule
